// File: rtl/dma_controller_if.sv
// -----------------------------------------------------------------------------
// dma_controller_if
//   Handshake and memory-bus bundle between the DMA engine, the CPU and the
//   device buffer. The bidirectional d_data bus stays a plain port on the
//   engine so tristate resolution remains outside the interface.
//
//   Signals:
//     cmd        CPU -> DMA   start request (level)
//     BG         CPU -> DMA   bus grant
//     dev_data   dev -> DMA   64-bit device block selected by dev_offset
//     BR         DMA -> CPU   bus request
//     dma_end    DMA -> CPU   one-cycle completion pulse
//     dev_offset DMA -> dev   index of the current device block
//     d_writeM   DMA -> mem   data-memory write strobe
//     d_address  DMA -> mem   data-memory word address
//
//   Modports:
//     master  the DMA engine side
//     slave   the CPU / memory / device side
// -----------------------------------------------------------------------------
interface dma_controller_if;
  logic        cmd;
  logic        BG;
  logic [63:0] dev_data;
  logic        BR;
  logic        dma_end;
  logic [3:0]  dev_offset;
  logic        d_writeM;
  logic [15:0] d_address;

  modport master (
    input  cmd, BG, dev_data,
    output BR, dma_end, dev_offset, d_writeM, d_address
  );

  modport slave (
    output cmd, BG, dev_data,
    input  BR, dma_end, dev_offset, d_writeM, d_address
  );
endinterface

// File: rtl/dma_controller.sv
// -----------------------------------------------------------------------------
// dma_controller
//   Bus-master DMA engine. On a CPU start request it raises BR, waits for the
//   grant BG, then copies NUM_BURSTS device blocks into data memory starting
//   at BASE_ADDR. Each 64-bit block write holds d_writeM for BURST_CYCLES
//   cycles; the destination address advances by 4 words per block. A single
//   dma_end pulse marks completion.
//
//   Ports:
//     Clk      in     clock, all state on the rising edge
//     Reset_N  in     asynchronous active-low reset
//     bus      master handshake / memory bus bundle (dma_controller_if)
//     d_data   inout  drives dev_data while writing, otherwise high-Z
//
//   All outputs decode registered state and counters; only the write strobe
//   and data bus also follow the live grant so that a withdrawn grant
//   releases the memory bus in the same cycle.
// -----------------------------------------------------------------------------
module dma_controller #(
  parameter logic [15:0] BASE_ADDR    = 16'h01F4,
  parameter int unsigned NUM_BURSTS   = 3,
  parameter int unsigned BURST_CYCLES = 4
) (
  input  logic               Clk,
  input  logic               Reset_N,
  dma_controller_if.master   bus,
  inout  wire  [63:0]        d_data
);

  localparam logic [3:0] LAST_CYC   = 4'(BURST_CYCLES - 1);
  localparam logic [3:0] LAST_BURST = 4'(NUM_BURSTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] burst_r;
  logic [3:0] burst_nxt_s;
  logic [3:0] cyc_r;
  logic [3:0] cyc_nxt_s;
  logic       in_xfer_s;
  logic       write_en_s;

  // State and counter registers.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_r <= IDLE;
      burst_r <= 4'd0;
      cyc_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      burst_r <= burst_nxt_s;
      cyc_r   <= cyc_nxt_s;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_nxt_s = state_r;
    burst_nxt_s = burst_r;
    cyc_nxt_s   = cyc_r;
    case (state_r)
      IDLE: begin
        if (bus.cmd) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (bus.BG) begin
          state_nxt_s = XFER;
          burst_nxt_s = 4'd0;
          cyc_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = REQ;
        end
      end
      XFER: begin
        // Counters only advance on granted cycles, so a withdrawn grant
        // resumes exactly where it stopped.
        if (bus.BG) begin
          if (cyc_r < LAST_CYC) begin
            cyc_nxt_s = cyc_r + 4'd1;
          end else begin
            cyc_nxt_s = 4'd0;
            if (burst_r == LAST_BURST) begin
              state_nxt_s = DONE;
            end else begin
              burst_nxt_s = burst_r + 4'd1;
            end
          end
        end else begin
          state_nxt_s = XFER;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        burst_nxt_s = 4'd0;
        cyc_nxt_s   = 4'd0;
      end
      default: begin
        state_nxt_s = IDLE;
        burst_nxt_s = 4'd0;
        cyc_nxt_s   = 4'd0;
      end
    endcase
  end

  assign in_xfer_s  = (state_r == XFER);
  assign write_en_s = in_xfer_s && bus.BG;

  assign bus.BR         = (state_r == REQ) || in_xfer_s;
  assign bus.dma_end    = (state_r == DONE);
  assign bus.d_writeM   = write_en_s;
  // Address and offset stay on the current block during a grant pause.
  assign bus.dev_offset = in_xfer_s ? burst_r : 4'd0;
  assign bus.d_address  = in_xfer_s ? (BASE_ADDR + {10'd0, burst_r, 2'b00}) : 16'd0;

  assign d_data = write_en_s ? bus.dev_data : {64{1'bz}};

endmodule

// File: tb/tb_dma_controller.sv
// -----------------------------------------------------------------------------
// tb_dma_controller
//   Scoreboard bench: stimulus pushes the expected write beats and completion
//   pulses into queues; negedge monitors pop and compare whenever a DUT writes
//   or signals dma_end. A second instance uses single-beat parameters.
// -----------------------------------------------------------------------------
module tb_dma_controller;

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  off;
  } beat_t;

  logic      Clk;
  logic      Reset_N;
  wire [63:0] d_data;
  wire [63:0] d_data2;

  int vectors     = 0;
  int miscompares = 0;

  beat_t exp_q[$];
  bit    end_q[$];
  beat_t exp_q2[$];
  bit    end_q2[$];
  beat_t mb;
  beat_t mb2;

  dma_controller_if bus();
  dma_controller_if bus2();

  dma_controller dut (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .bus     (bus.master),
    .d_data  (d_data)
  );

  dma_controller #(
    .NUM_BURSTS   (1),
    .BURST_CYCLES (1)
  ) dut2 (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .bus     (bus2.master),
    .d_data  (d_data2)
  );

  function automatic logic [63:0] pat(input logic [3:0] o);
    return {16'hC0DE, 12'h000, o, 32'h1234_5678};
  endfunction

  assign bus.dev_data  = pat(bus.dev_offset);
  assign bus2.dev_data = pat(bus2.dev_offset);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the default-parameter instance.
  always @(negedge Clk) begin
    if (Reset_N) begin
      if (bus.d_writeM) begin
        if (exp_q.size() == 0) begin
          chk("unexpected write", {48'd0, bus.d_address}, 64'hFFFF);
        end else begin
          mb = exp_q.pop_front();
          chk("write addr", {48'd0, bus.d_address}, {48'd0, mb.addr});
          chk("write offset", {60'd0, bus.dev_offset}, {60'd0, mb.off});
          chk("write data", d_data, pat(mb.off));
        end
      end
      if (bus.dma_end) begin
        chk("dma_end expected", {63'd0, end_q.size() != 0}, 64'd1);
        if (end_q.size() != 0) void'(end_q.pop_front());
        chk("done BR", {63'd0, bus.BR}, 64'd0);
        chk("done writeM", {63'd0, bus.d_writeM}, 64'd0);
      end
    end
  end

  // Scoreboard monitor for the single-beat instance.
  always @(negedge Clk) begin
    if (Reset_N) begin
      if (bus2.d_writeM) begin
        if (exp_q2.size() == 0) begin
          chk("t6 unexpected write", {48'd0, bus2.d_address}, 64'hFFFF);
        end else begin
          mb2 = exp_q2.pop_front();
          chk("t6 write addr", {48'd0, bus2.d_address}, {48'd0, mb2.addr});
          chk("t6 write data", d_data2, pat(mb2.off));
        end
      end
      if (bus2.dma_end) begin
        chk("t6 dma_end expected", {63'd0, end_q2.size() != 0}, 64'd1);
        if (end_q2.size() != 0) void'(end_q2.pop_front());
      end
    end
  end

  task automatic push_xfer(input int nb, input int nc, input bit with_end);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < nc; c++) begin
        b.addr = 16'h01F4 + 16'(4 * i);
        b.off  = 4'(i);
        exp_q.push_back(b);
      end
    end
    if (with_end) end_q.push_back(1'b1);
  endtask

  task automatic pulse_cmd(input string name);
    @(posedge Clk); #1 bus.cmd = 1'b1;
    @(posedge Clk); #1 bus.cmd = 1'b0;
    chk({name, " BR after cmd"}, {63'd0, bus.BR}, 64'd1);
  endtask

  task automatic wait_end(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge Clk);
      if (bus.dma_end) found = 1'b1;
    end
    chk({name, " dma_end seen"}, {63'd0, found}, 64'd1);
  endtask

  task automatic drained(input string name);
    chk({name, " beats left"}, 64'(exp_q.size()), 64'd0);
    chk({name, " ends left"}, 64'(end_q.size()), 64'd0);
  endtask

  initial begin
    Reset_N   = 1'b0;
    bus.cmd   = 1'b0;
    bus.BG    = 1'b0;
    bus2.cmd  = 1'b0;
    bus2.BG   = 1'b0;
    repeat (2) @(negedge Clk);
    chk("reset BR", {63'd0, bus.BR}, 64'd0);
    chk("reset dma_end", {63'd0, bus.dma_end}, 64'd0);
    chk("reset writeM", {63'd0, bus.d_writeM}, 64'd0);
    chk("reset addr", {48'd0, bus.d_address}, 64'd0);
    chk("reset offset", {60'd0, bus.dev_offset}, 64'd0);
    @(posedge Clk); #1 Reset_N = 1'b1;

    // 1: basic transfer, grant one cycle after BR.
    push_xfer(3, 4, 1'b1);
    pulse_cmd("t1");
    chk("t1 no write in REQ", {63'd0, bus.d_writeM}, 64'd0);
    bus.BG = 1'b1;
    wait_end("t1");
    @(negedge Clk);
    bus.BG = 1'b0;
    chk("t1 idle BR", {63'd0, bus.BR}, 64'd0);
    chk("t1 idle dma_end", {63'd0, bus.dma_end}, 64'd0);
    drained("t1");

    // 2: grant held off for 7 cycles.
    push_xfer(3, 4, 1'b1);
    pulse_cmd("t2");
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk);
      chk("t2 wait BR", {63'd0, bus.BR}, 64'd1);
      chk("t2 wait writeM", {63'd0, bus.d_writeM}, 64'd0);
      chk("t2 wait addr", {48'd0, bus.d_address}, 64'd0);
    end
    @(posedge Clk); #1 bus.BG = 1'b1;
    @(negedge Clk);
    chk("t2 no write before edge", {63'd0, bus.d_writeM}, 64'd0);
    wait_end("t2");
    @(negedge Clk);
    bus.BG = 1'b0;
    drained("t2");

    // 3: grant dropped for 3 cycles at the second cycle of block 1.
    push_xfer(3, 4, 1'b1);
    pulse_cmd("t3");
    bus.BG = 1'b1;
    repeat (6) @(posedge Clk);
    #1 bus.BG = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("t3 pause writeM", {63'd0, bus.d_writeM}, 64'd0);
      chk("t3 pause BR", {63'd0, bus.BR}, 64'd1);
      chk("t3 pause addr", {48'd0, bus.d_address}, 64'h01F8);
    end
    @(posedge Clk); #1 bus.BG = 1'b1;
    wait_end("t3");
    @(negedge Clk);
    bus.BG = 1'b0;
    drained("t3");

    // 4: cmd re-asserted mid-transfer and held through DONE.
    push_xfer(3, 4, 1'b1);
    push_xfer(3, 4, 1'b1);
    pulse_cmd("t4");
    bus.BG = 1'b1;
    repeat (5) @(posedge Clk);
    #1 bus.cmd = 1'b1;
    wait_end("t4 first");
    @(negedge Clk);
    chk("t4 idle BR", {63'd0, bus.BR}, 64'd0);
    chk("t4 idle dma_end", {63'd0, bus.dma_end}, 64'd0);
    @(negedge Clk);
    chk("t4 new REQ BR", {63'd0, bus.BR}, 64'd1);
    chk("t4 new REQ writeM", {63'd0, bus.d_writeM}, 64'd0);
    bus.cmd = 1'b0;
    wait_end("t4 second");
    @(negedge Clk);
    bus.BG = 1'b0;
    drained("t4");

    // 5: reset in the middle of block 1.
    push_xfer(1, 4, 1'b0);
    push_xfer(0, 0, 1'b0);
    begin
      beat_t b;
      b.addr = 16'h01F8;
      b.off  = 4'd1;
      exp_q.push_back(b);
      exp_q.push_back(b);
    end
    pulse_cmd("t5");
    bus.BG = 1'b1;
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    #1 Reset_N = 1'b0;
    #1;
    chk("t5 reset BR", {63'd0, bus.BR}, 64'd0);
    chk("t5 reset writeM", {63'd0, bus.d_writeM}, 64'd0);
    chk("t5 reset dma_end", {63'd0, bus.dma_end}, 64'd0);
    chk("t5 reset addr", {48'd0, bus.d_address}, 64'd0);
    chk("t5 reset offset", {60'd0, bus.dev_offset}, 64'd0);
    bus.BG = 1'b0;
    drained("t5 partial");
    @(posedge Clk); #1 Reset_N = 1'b1;
    @(negedge Clk);
    chk("t5 idle BR", {63'd0, bus.BR}, 64'd0);
    push_xfer(3, 4, 1'b1);
    pulse_cmd("t5 restart");
    bus.BG = 1'b1;
    wait_end("t5 restart");
    @(negedge Clk);
    bus.BG = 1'b0;
    drained("t5 restart");

    // 6: single one-cycle block on the second instance.
    begin
      beat_t b;
      b.addr = 16'h01F4;
      b.off  = 4'd0;
      exp_q2.push_back(b);
      end_q2.push_back(1'b1);
    end
    @(posedge Clk); #1 bus2.cmd = 1'b1;
    @(posedge Clk); #1 bus2.cmd = 1'b0;
    chk("t6 BR after cmd", {63'd0, bus2.BR}, 64'd1);
    bus2.BG = 1'b1;
    @(negedge Clk);
    chk("t6 no write in REQ", {63'd0, bus2.d_writeM}, 64'd0);
    @(negedge Clk);
    chk("t6 write cycle", {63'd0, bus2.d_writeM}, 64'd1);
    @(negedge Clk);
    chk("t6 dma_end", {63'd0, bus2.dma_end}, 64'd1);
    chk("t6 done writeM", {63'd0, bus2.d_writeM}, 64'd0);
    @(negedge Clk);
    bus2.BG = 1'b0;
    chk("t6 idle dma_end", {63'd0, bus2.dma_end}, 64'd0);
    chk("t6 idle BR", {63'd0, bus2.BR}, 64'd0);
    chk("t6 beats left", 64'(exp_q2.size()), 64'd0);
    chk("t6 ends left", 64'(end_q2.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
